stack_ctrl: RTL and testbench

Control stage directly upstream of the 8×4 stack memory (`stack_mem`). It converts raw push/pop requests into the memory's `pushenbl`/`popenbl` strobes and maintains the `tos` pointer and full/empty state. It also flags overflow, underflow and push/pop collisions, and marks when `popdataout` from the memory is valid. Its outputs drive the memory's `pushenbl`, `popenbl`, `tos` and `stack_full` inputs directly.

---
 rtl/stack_pkg.sv | 13 +
 rtl/stack_ctrl.sv | 91 +++++++++
 tb/tb_stack_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared constants and state encoding for the stack controller and stack memory.
package stack_pkg;

  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned STACK_AW    = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } stack_state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Push/pop controller in front of the stack memory: gates request strobes,
// tracks tos/count/state, and raises sticky overflow/underflow/collision flags.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = STACK_DEPTH,
  parameter int unsigned AW    = STACK_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic          err_clr,
  output logic          pushenbl,
  output logic          popenbl,
  output logic [0:AW-1] tos,
  output logic          stack_full,
  output logic          stack_empty,
  output logic [AW:0]   count,
  output logic          pop_valid,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic          collision_err
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  stack_state_t  state, state_nxt;
  logic [AW-1:0] tos_q, tos_nxt;
  logic [CW-1:0] count_nxt;
  logic          ovf_set, unf_set, col_set;

  assign tos = tos_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      tos_q         <= '0;
      count         <= '0;
      stack_empty   <= 1'b1;
      stack_full    <= 1'b0;
      pop_valid     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      collision_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      tos_q         <= tos_nxt;
      count         <= count_nxt;
      stack_empty   <= (state_nxt == EMPTY);
      stack_full    <= (state_nxt == FULL);
      pop_valid     <= popenbl;
      overflow_err  <= ovf_set | (overflow_err  & ~err_clr);
      underflow_err <= unf_set | (underflow_err & ~err_clr);
      collision_err <= col_set | (collision_err & ~err_clr);
    end
  end

  // Next state, pointer and count; pop takes priority over push
  always_comb begin
    state_nxt = state;
    tos_nxt   = tos_q;
    count_nxt = count;
    if (popenbl) begin
      count_nxt = count - CW'(1);
      // In FULL the pointer already addresses the top entry
      if (state != FULL) tos_nxt = tos_q - AW'(1);
      state_nxt = (count == CW'(1)) ? EMPTY : PARTIAL;
    end else if (pushenbl) begin
      count_nxt = count + CW'(1);
      if (count == CNT_LAST) begin
        state_nxt = FULL;
      end else begin
        tos_nxt   = tos_q + AW'(1);
        state_nxt = PARTIAL;
      end
    end
  end

  // Memory strobes and error detection
  always_comb begin
    popenbl  = ~rst & pop_req & ~stack_empty;
    pushenbl = ~rst & push_req & ~stack_full & ~popenbl;
    ovf_set  = push_req & (state == FULL) & ~popenbl;
    unf_set  = pop_req & (state == EMPTY);
    col_set  = push_req & pop_req & popenbl;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl: a queue-based stack model predicts strobes,
// pointer, flags and popped data; a small array stands in for stack_mem.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int unsigned DEPTH = STACK_DEPTH;
  localparam int unsigned AW    = STACK_AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_req = 1'b0;
  logic          pop_req = 1'b0;
  logic          err_clr = 1'b0;
  logic          pushenbl, popenbl;
  logic [0:AW-1] tos;
  logic          stack_full, stack_empty;
  logic [AW:0]   count;
  logic          pop_valid, overflow_err, underflow_err, collision_err;

  logic [3:0] din = '0;
  logic [3:0] mem [DEPTH];
  logic [3:0] popdataout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_count = 0;
  logic [3:0] m_q[$];
  bit         m_ovf = 0, m_unf = 0, m_col = 0;

  stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req),
    .err_clr(err_clr), .pushenbl(pushenbl), .popenbl(popenbl), .tos(tos),
    .stack_full(stack_full), .stack_empty(stack_empty), .count(count),
    .pop_valid(pop_valid), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .collision_err(collision_err)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for stack_mem: reads tos when full, else tos-1
  always @(posedge clk) begin
    if (pushenbl) mem[tos] <= din;
    if (popenbl) popdataout <= stack_full ? mem[tos] : mem[tos - 1'b1];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit pu, input bit po, input bit clr,
                      input logic [3:0] d);
    bit e_pop, e_push, s_ovf, s_unf, s_col;
    logic [3:0] e_data;
    int e_tos;
    @(negedge clk);
    rst = r; push_req = pu; pop_req = po; err_clr = clr; din = d;
    #1;
    e_pop  = !r && po && (m_count > 0);
    e_push = !r && pu && (m_count < DEPTH) && !e_pop;
    check_eq("popenbl", 32'(popenbl), 32'(e_pop));
    check_eq("pushenbl", 32'(pushenbl), 32'(e_push));
    @(posedge clk);
    #1;
    e_data = '0;
    if (r) begin
      m_count = 0;
      m_q.delete();
      m_ovf = 0; m_unf = 0; m_col = 0;
    end else begin
      s_ovf = pu && (m_count == DEPTH) && !e_pop;
      s_unf = po && (m_count == 0);
      s_col = pu && po && e_pop;
      m_ovf = s_ovf || (m_ovf && !clr);
      m_unf = s_unf || (m_unf && !clr);
      m_col = s_col || (m_col && !clr);
      if (e_pop) begin
        e_data = m_q.pop_back();
        m_count--;
      end else if (e_push) begin
        m_q.push_back(d);
        m_count++;
      end
    end
    e_tos = (m_count == DEPTH) ? DEPTH - 1 : m_count;
    check_eq("pop_valid", 32'(pop_valid), 32'(e_pop));
    if (e_pop) check_eq("popdata", 32'(popdataout), 32'(e_data));
    check_eq("count", 32'(count), 32'(m_count));
    check_eq("tos", 32'(tos), 32'(e_tos));
    check_eq("stack_full", 32'(stack_full), 32'(m_count == DEPTH));
    check_eq("stack_empty", 32'(stack_empty), 32'(m_count == 0));
    check_eq("overflow_err", 32'(overflow_err), 32'(m_ovf));
    check_eq("underflow_err", 32'(underflow_err), 32'(m_unf));
    check_eq("collision_err", 32'(collision_err), 32'(m_col));
  endtask

  initial begin
    int mode, p_push, p_pop;
    step(1, 0, 0, 0, 4'h0);
    step(1, 1, 1, 0, 4'h0);
    // Fill with 1..8
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 4'(i));
    // Overflow then clear
    step(0, 1, 0, 0, 4'hF);
    step(0, 0, 0, 1, 4'h0);
    // Drain: expect 8..1
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 4'h0);
    // Underflow with simultaneous push of 0xA
    step(0, 1, 1, 0, 4'hA);
    step(0, 0, 0, 1, 4'h0);
    step(0, 1, 0, 0, 4'h3);
    step(0, 1, 0, 0, 4'h4);
    // Collision at count 3
    step(0, 1, 1, 0, 4'h7);
    step(0, 1, 0, 0, 4'h5);
    step(0, 1, 0, 0, 4'h6);
    step(0, 1, 0, 0, 4'h9);
    // Reset mid-operation with count 5 and a pop request
    step(1, 0, 1, 0, 4'h0);
    step(0, 0, 1, 0, 4'h0);
    // Randomized phases: push-heavy, pop-heavy, balanced
    for (int i = 0; i < 3000; i++) begin
      mode   = (i / 150) % 3;
      p_push = (mode == 0) ? 80 : (mode == 1) ? 25 : 50;
      p_pop  = (mode == 0) ? 20 : (mode == 1) ? 75 : 50;
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < p_push,
           $urandom_range(0, 99) < p_pop,
           $urandom_range(0, 7) == 0,
           4'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
